// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the instruction RAM.
// Packs incoming bytes little-endian into 32-bit words, writes them
// sequentially from word 0, and keeps the CPU in reset until the image is
// complete. The fetch-side read port is combinational (byte address in).
// Optional trailer-byte checksum: define IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_start_i,
    input  logic [AW:0]   load_len_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    input  logic [DW-1:0] a_i,
    output logic [DW-1:0] rd_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          cpu_rst_o,
    output logic [AW:0]   word_count_o
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic          cksum_err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
`ifdef IMEM_LOADER_CKSUM_EN
        ,
        S_CHECK
`endif
    } state_t;

    // Largest legal image: the whole RAM.
    localparam logic [AW:0] MAX_LEN = (AW+1)'(2**AW);

    state_t        state_reg, state_next;
    logic [1:0]    lane_reg, lane_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW:0]   len_reg, len_next;
    logic [7:0]    asm_bytes [0:2];
    logic          mem_we;
    logic          accept;
    logic [DW-1:0] mem [0:2**AW-1];

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] sum_reg, sum_next;
    logic       err_reg, err_next;
`endif

    // Ready is decoded from state only, so it never depends on byte_valid_i.
    always_comb begin
        byte_ready_o = (state_reg == S_LOAD);
`ifdef IMEM_LOADER_CKSUM_EN
        byte_ready_o = byte_ready_o || (state_reg == S_CHECK);
`endif
    end

    assign busy_o       = byte_ready_o;
    assign done_o       = (state_reg == S_DONE);
    assign word_count_o = count_reg;
    assign accept       = byte_valid_i && byte_ready_o;

`ifdef IMEM_LOADER_CKSUM_EN
    assign cpu_rst_o   = !done_o || err_reg;
    assign cksum_err_o = err_reg;
`else
    assign cpu_rst_o   = !done_o;
`endif

    // Next-state and datapath-update decode.
    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        count_next = count_reg;
        len_next   = len_reg;
        mem_we     = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_next   = sum_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (load_start_i) begin
                    // Lengths above the RAM depth are clamped to a full image.
                    len_next   = load_len_i[AW] ? MAX_LEN : load_len_i;
                    lane_next  = 2'd0;
                    count_next = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_next   = 8'd0;
                    err_next   = 1'b0;
                    state_next = (len_next == '0) ? S_CHECK : S_LOAD;
`else
                    state_next = (len_next == '0) ? S_DONE : S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    lane_next = lane_reg + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_next  = sum_reg + byte_data_i;
`endif
                    if (lane_reg == 2'd3) begin
                        mem_we     = 1'b1;
                        count_next = count_reg + (AW+1)'(1);
                        if (count_next == len_reg) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            state_next = S_CHECK;
`else
                            state_next = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    err_next   = ((sum_reg + byte_data_i) != 8'd0);
                    state_next = S_DONE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            lane_reg  <= 2'd0;
            count_reg <= '0;
            len_reg   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_reg   <= 8'd0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
            count_reg <= count_next;
            len_reg   <= len_next;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_reg   <= sum_next;
            err_reg   <= err_next;
`endif
        end
    end

    // Assembly lanes 0..2; lane 3 goes straight from the input into the RAM.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            // Capture the byte destined for this lane.
            always_ff @(posedge clk_i) begin
                if (accept && (state_reg == S_LOAD) && (lane_reg == 2'(gi))) begin
                    asm_bytes[gi] <= byte_data_i;
                end
            end
        end
    endgenerate

    // RAM write of a completed word; reset on the same edge suppresses it.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem[count_reg[AW-1:0]] <= {byte_data_i, asm_bytes[2], asm_bytes[1], asm_bytes[0]};
        end
    end

    // Fetch port: word-addressed, low and high address bits alias.
    assign rd_o = mem[a_i[AW+1:2]];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_i[1:0], a_i[DW-1:AW+2]};

endmodule
